// File: rtl/vga_sprite_ctrl_if.sv
// Pixel-memory read port between vga_sprite_ctrl (master) and a synchronous-read sprite RAM (slave).
// Handshake: mem_en/mem_addr are held for a whole pixel; the slave returns the word for an address
// on mem_data exactly RD_LAT clocks after sampling it. There is no back-pressure.
interface vga_sprite_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (output mem_en, output mem_addr, input mem_data);
    modport slave  (input mem_en, input mem_addr, output mem_data);
endinterface

// File: rtl/vga_sprite_ctrl.sv
// VGA timing generator with one positionable sprite fetched from a synchronous pixel memory.
// Define SPRITE_KEY_EN to make sprite pixels equal to KEY_COLOR transparent.
module vga_sprite_ctrl #(
    parameter int         CLK_DIV    = 4,
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 29,
    parameter int         SPR_W_LOG2 = 8,
    parameter int         SPR_H_LOG2 = 8,
    parameter int         RD_LAT     = 1,
    parameter logic [7:0] BG_COLOR   = 8'h00,
    parameter logic [7:0] KEY_COLOR  = 8'hE3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               spr_en_in,
    input  logic               pos_wr,
    vga_sprite_ctrl_if.master  mem,
    output logic [2:0]         red,
    output logic [2:0]         green,
    output logic [1:0]         blue,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start
);

    localparam int         H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int         DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int         AW    = SPR_W_LOG2 + SPR_H_LOG2;
    localparam logic [10:0] SPR_W = 11'(1 << SPR_W_LOG2);
    localparam logic [10:0] SPR_H = 11'(1 << SPR_H_LOG2);

    // Sync flags are carried active-high so a cleared pipeline means "no sync pulse".
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic hit;
        logic fs;
    } ctl_t;

    logic [DW-1:0] div;
    logic [10:0]   hc, vc, hc_nxt, vc_nxt;
    logic [9:0]    act_x, act_y, pend_x, pend_y, nxt_x, nxt_y;
    logic          act_en, pend_en, nxt_en;
    logic          tick, frame_end, hit_nxt;
    logic [AW-1:0] addr_nxt, mem_addr_q;
    logic          mem_en_q;
    ctl_t          raw, last;
    ctl_t          pipe [RD_LAT];
    logic [7:0]    spr_pix, pix;

    function automatic logic in_sprite(input logic [10:0] h, input logic [10:0] v,
                                       input logic [9:0] px, input logic [9:0] py,
                                       input logic en);
        logic [10:0] x0, y0;
        x0 = {1'b0, px};
        y0 = {1'b0, py};
        return en && (h < 11'(H_ACTIVE)) && (v < 11'(V_ACTIVE)) &&
               (h >= x0) && (h < x0 + SPR_W) && (v >= y0) && (v < y0 + SPR_H);
    endfunction

    assign tick      = (div == DW'(CLK_DIV - 1));
    assign frame_end = tick && (hc == 11'(H_TOT - 1)) && (vc == 11'(V_TOT - 1));

    always_comb begin
        hc_nxt = hc;
        vc_nxt = vc;
        if (tick) begin
            if (hc == 11'(H_TOT - 1)) begin
                hc_nxt = 11'd0;
                vc_nxt = (vc == 11'(V_TOT - 1)) ? 11'd0 : vc + 11'd1;
            end else begin
                hc_nxt = hc + 11'd1;
            end
        end
    end

    // A write landing on the commit clock bypasses the pending registers.
    always_comb begin
        nxt_x  = act_x;
        nxt_y  = act_y;
        nxt_en = act_en;
        if (frame_end) begin
            nxt_x  = pos_wr ? pos_x     : pend_x;
            nxt_y  = pos_wr ? pos_y     : pend_y;
            nxt_en = pos_wr ? spr_en_in : pend_en;
        end
    end

    // The fetch is registered from next-state counters so the address changes on the same clock
    // as hc/vc; that leaves the memory exactly RD_LAT clocks before the colour register.
    assign hit_nxt  = in_sprite(hc_nxt, vc_nxt, nxt_x, nxt_y, nxt_en);
    assign addr_nxt = {vc_nxt[SPR_H_LOG2-1:0] - nxt_y[SPR_H_LOG2-1:0],
                       hc_nxt[SPR_W_LOG2-1:0] - nxt_x[SPR_W_LOG2-1:0]};

    always_comb begin
        raw     = '0;
        raw.hs  = (hc >= 11'(H_ACTIVE + H_FP)) && (hc < 11'(H_ACTIVE + H_FP + H_SYNC));
        raw.vs  = (vc >= 11'(V_ACTIVE + V_FP)) && (vc < 11'(V_ACTIVE + V_FP + V_SYNC));
        raw.de  = (hc < 11'(H_ACTIVE)) && (vc < 11'(V_ACTIVE));
        raw.hit = mem_en_q;
        raw.fs  = (hc == 11'd0) && (vc == 11'd0) && (div == '0);
    end

    assign last = pipe[RD_LAT-1];

`ifdef SPRITE_KEY_EN
    assign spr_pix = (mem.mem_data == KEY_COLOR) ? BG_COLOR : mem.mem_data;
`else
    logic unused_key;
    assign unused_key = ^KEY_COLOR;
    assign spr_pix    = mem.mem_data;
`endif

    always_comb begin
        pix = 8'h00;
        if (last.de) begin
            pix = last.hit ? spr_pix : BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            hc          <= '0;
            vc          <= '0;
            act_x       <= '0;
            act_y       <= '0;
            act_en      <= 1'b0;
            pend_x      <= '0;
            pend_y      <= '0;
            pend_en     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div    <= tick ? '0 : div + 1'b1;
            hc     <= hc_nxt;
            vc     <= vc_nxt;
            act_x  <= nxt_x;
            act_y  <= nxt_y;
            act_en <= nxt_en;
            if (pos_wr) begin
                pend_x  <= pos_x;
                pend_y  <= pos_y;
                pend_en <= spr_en_in;
            end
            mem_en_q <= hit_nxt;
            if (hit_nxt) begin
                mem_addr_q <= addr_nxt;
            end
            pipe[0] <= raw;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            {blue, green, red} <= pix;
            hsync       <= ~last.hs;
            vsync       <= ~last.vs;
            de          <= last.de;
            frame_start <= last.fs;
        end
    end

    assign mem.mem_en   = mem_en_q;
    assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Directed bench for vga_sprite_ctrl on a shrunken 24x17-pixel raster with a 4x4 sprite,
// CLK_DIV=2 and RD_LAT=2, so a pixel started at clock k reaches the pins after clock k+3.
module tb_vga_sprite_ctrl;

    localparam int         CLK_DIV = 2;
    localparam int         RD_LAT  = 2;
    localparam int         AW      = 4;
    localparam logic [7:0] BG      = 8'h1C;
`ifdef SPRITE_KEY_EN
    localparam logic [7:0] KEY_EXP = BG;
`else
    localparam logic [7:0] KEY_EXP = 8'hE3;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    pos_x = '0;
    logic [9:0]    pos_y = '0;
    logic          spr_en_in = 1'b0;
    logic          pos_wr = 1'b0;
    logic [2:0]    red, green;
    logic [1:0]    blue;
    logic          hsync, vsync, de, frame_start;
    logic [7:0]    rgb;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc;
    int            hs_falls;
    logic          hs_d = 1'b1;
    logic [7:0]    rd_q [RD_LAT];

    vga_sprite_ctrl_if #(.ADDR_W(AW)) mem ();

    vga_sprite_ctrl #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SPR_W_LOG2(2), .SPR_H_LOG2(2), .RD_LAT(RD_LAT),
        .BG_COLOR(BG), .KEY_COLOR(8'hE3)
    ) dut (
        .clk(clk), .reset(reset), .pos_x(pos_x), .pos_y(pos_y),
        .spr_en_in(spr_en_in), .pos_wr(pos_wr), .mem(mem),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_start(frame_start)
    );

    // clock and cycle bookkeeping
    always #5 clk = ~clk;
    assign rgb = {blue, green, red};

    always @(posedge clk) begin
        cyc  <= reset ? 0 : cyc + 1;
        hs_d <= hsync;
        if (reset) hs_falls <= 0;
        else if (hs_d && !hsync) hs_falls <= hs_falls + 1;
    end

    // sprite RAM: word 5 holds the key colour, every other word is 0x40 | addr
    function automatic logic [7:0] mem_word(input logic [AW-1:0] a);
        return (a == 4'd5) ? 8'hE3 : {4'h4, a};
    endfunction

    always @(posedge clk) begin
        if (mem.mem_en) rd_q[0] <= mem_word(mem.mem_addr);
        for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
    end
    assign mem.mem_data = rd_q[RD_LAT-1];

    // checking and driver tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("goto", 32'(cyc), 32'(n));
    endtask

    task automatic write_pos(input logic [9:0] x, input logic [9:0] y, input logic en);
        pos_x = x;
        pos_y = y;
        spr_en_in = en;
        pos_wr = 1'b1;
        @(negedge clk);
        pos_wr = 1'b0;
    endtask

    task automatic check_pix(input string tag, input logic exp_de, input logic [7:0] exp_rgb);
        check({tag, "_de"}, 32'(de), 32'(exp_de));
        check({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
    endtask

    task automatic check_mem(input string tag, input logic exp_en, input logic [AW-1:0] exp_addr);
        check({tag, "_en"}, 32'(mem.mem_en), 32'(exp_en));
        check({tag, "_addr"}, 32'(mem.mem_addr), 32'(exp_addr));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check_pix(tag, 1'b0, 8'h00);
        check_mem(tag, 1'b0, 4'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (10) @(negedge clk);
        check_reset("rst");
        reset = 1'b0;

        // frame 0: timing only, sprite still disabled
        goto(3);    check_pix("f0_p00", 1'b1, BG); check("f0_fs", 32'(frame_start), 32'd1);
        goto(4);    check("f0_fs_end", 32'(frame_start), 32'd0);
        goto(34);   check("f0_de_p15", 32'(de), 32'd1);
        goto(35);   check_pix("f0_p16", 1'b0, 8'h00);
        goto(38);   check("hs_pre", 32'(hsync), 32'd1);
        goto(39);   check("hs_fall", 32'(hsync), 32'd0);
        goto(44);   check("hs_last", 32'(hsync), 32'd0);
        goto(45);   check("hs_rise", 32'(hsync), 32'd1);
        goto(50);   write_pos(10'd5, 10'd3, 1'b1);
        goto(154);  check("f0_no_fetch", 32'(mem.mem_en), 32'd0);
        goto(157);  check_pix("f0_p53", 1'b1, BG);
        goto(626);  check("vs_pre", 32'(vsync), 32'd1);
        goto(627);  check("vs_fall", 32'(vsync), 32'd0);
        goto(722);  check("vs_last", 32'(vsync), 32'd0);
        goto(723);  check("vs_rise", 32'(vsync), 32'd1);
        goto(819);  check("hs_per_frame", 32'(hs_falls), 32'd17);

        // frame 1: sprite at (5,3)
        goto(970);  check_mem("f1_m53", 1'b1, 4'd0);
        goto(971);  check_pix("f1_p43", 1'b1, BG);
        goto(973);  check_pix("f1_p53", 1'b1, 8'h40);
        goto(981);  check_pix("f1_p93", 1'b1, BG);
        goto(1020); check_mem("f1_m64", 1'b1, 4'd5);
        goto(1023); check_pix("f1_key", 1'b1, KEY_EXP);
        goto(1056); write_pos(10'd13, 10'd10, 1'b1);
        goto(1070); check_mem("f1_m75", 1'b1, 4'd10);
        goto(1073); check_pix("f1_p75", 1'b1, 8'h4A);
        goto(1120); check_mem("f1_m86", 1'b1, 4'd15);
        goto(1123); check_pix("f1_p86", 1'b1, 8'h4F);
        goto(1165); check_pix("f1_p57", 1'b1, BG);

        // frame 2: sprite at (13,10), clipped right and bottom
        goto(2016); write_pos(10'd2, 10'd2, 1'b1);
        goto(2138); check_mem("f2_m1310", 1'b1, 4'd0);
        goto(2141); check_pix("f2_p1310", 1'b1, 8'h40);
        goto(2190); check_mem("f2_m1511", 1'b1, 4'd6);
        goto(2192); check_mem("f2_m1611", 1'b0, 4'd6);
        goto(2193); check_pix("f2_p1511", 1'b1, 8'h46);
        goto(2195); check_pix("f2_p1611", 1'b0, 8'h00);
        goto(2206); check("f2_m2311_en", 32'(mem.mem_en), 32'd0);
        goto(2234); check("f2_m1312_en", 32'(mem.mem_en), 32'd0);
        goto(2237); check_pix("f2_p1312", 1'b0, 8'h00);

        // write on the commit clock overrides the pending (2,2)
        goto(2447); write_pos(10'd0, 10'd0, 1'b1);
        check_mem("f3_m00", 1'b1, 4'd0);
        goto(2451); check_pix("f3_p00", 1'b1, 8'h40); check("f3_fs", 32'(frame_start), 32'd1);
        goto(2498); check_mem("f3_m11", 1'b1, 4'd5);
        goto(2501); check_pix("f3_key", 1'b1, KEY_EXP);
        goto(2548); check_mem("f3_m22", 1'b1, 4'd10);
        goto(2551); check_pix("f3_p22", 1'b1, 8'h4A);

        // mid-frame reset during an hsync pulse on line 8
        goto(2872);
        check("pre_rst_hs", 32'(hsync), 32'd0);
        check("pre_rst_addr", 32'(mem.mem_addr), 32'd15);
        reset = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        goto(3);    check_pix("r_p00", 1'b1, BG); check("r_fs", 32'(frame_start), 32'd1);
        goto(38);   check("r_hs_pre", 32'(hsync), 32'd1);
        goto(39);   check("r_hs_fall", 32'(hsync), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sprite_ctrl.md
Name: vga_sprite_ctrl

Overview:
Parametrised VGA timing generator with a single positionable sprite fetched from an external synchronous-read pixel memory. Generates hsync/vsync/de from configurable timing, divides the system clock down to the pixel rate, and computes a 2-D sprite address. Control signals are aligned to the memory read latency. Sprite position and enable are runtime-writable and are committed only at frame boundaries. The block sits between the pixel BRAM and the board DAC pins.

Parameters:
- CLK_DIV, 4: system clocks per pixel (>=1).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: hsync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vsync width.
- V_BP, 29: vertical back porch.
- SPR_W_LOG2, 8: log2 of sprite width.
- SPR_H_LOG2, 8: log2 of sprite height.
- RD_LAT, 1: memory read latency in clk cycles (>=1).
- BG_COLOR, 8'h00: colour outside the sprite within the active area.
- KEY_COLOR, 8'hE3: transparency key (used only with SPRITE_KEY_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pos_x  in  10  sprite left column, in active-area coordinates.
- pos_y  in  10  sprite top line.
- spr_en_in  in  1  sprite enable.
- pos_wr  in  1  one-cycle strobe capturing pos_x, pos_y and spr_en_in.
- mem_en  out  1  memory read enable.
- mem_addr  out  SPR_W_LOG2+SPR_H_LOG2  sprite pixel address.
- mem_data  in  8  pixel {B[1:0],G[2:0],R[2:0]}, valid RD_LAT clocks after the address.
- red  out  3  pixel colour, red.
- green  out  3  pixel colour, green.
- blue  out  2  pixel colour, blue.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- de  out  1  active-video flag, aligned with the colour outputs.
- frame_start  out  1  one-clock pulse, aligned with the first active pixel of a frame.

Behaviour:
- Reset values:
  - red/green/blue = 0; hsync = 1; vsync = 1; de = 0.
  - frame_start = 0; mem_en = 0; mem_addr = 0.
  - Counters, divider, active and pending position registers = 0; sprite disabled.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick when the divider = CLK_DIV-1.
  - CLK_DIV=1 gives a tick every clock.
- Counters, advanced on tick only:
  - hc = 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vc = 0..V_TOT-1; vc increments when hc wraps; vc wraps to 0 after V_TOT-1.
  - Active area is hc<H_ACTIVE && vc<V_ACTIVE.
- Sync windows:
  - Raw hsync is low for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - Raw vsync is low for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
- Sprite hit: spr_en && active && pos_x<=hc<pos_x+2^SPR_W_LOG2 && pos_y<=vc<pos_y+2^SPR_H_LOG2.
  - Compare using 11-bit sums so there is no wrap.
  - The sprite clips at the right and bottom edges of the active area.
- Addressing:
  - mem_addr = {(vc-pos_y)[SPR_H_LOG2-1:0], (hc-pos_x)[SPR_W_LOG2-1:0]}, registered.
  - mem_en = hit, registered.
  - Both are held for the whole pixel.
  - mem_addr holds its last value when there is no hit.
- Alignment:
  - Raw hsync, vsync, de, hit and frame_start pass through a RD_LAT-clock shift register.
  - This aligns them with mem_data.
  - Colour is then registered, together with the aligned hsync, vsync, de and frame_start.
  - Total latency from a counter change to the pins = RD_LAT+1 clocks, identical for all outputs.
- Colour select:
  - de=0 gives 0.
  - de=1 with hit gives mem_data.
  - de=1 without hit gives BG_COLOR.
- Position update:
  - pos_wr loads the pending registers.
  - Pending is copied to active on the tick where hc=H_TOT-1 and vc=V_TOT-1 (frame end).
  - If pos_wr coincides with the commit clock, the incoming values go straight into active.
  - Position never changes mid-frame.
- Reset mid-frame: everything returns to the reset values on the next clock; the shift registers are cleared.

Optional Feature:
- Macro: SPRITE_KEY_EN.
- Defined: a hit pixel whose mem_data equals KEY_COLOR outputs BG_COLOR (transparent).
- Undefined: every hit pixel outputs mem_data; KEY_COLOR is ignored.

Test Plan:
- Timing from reset: defaults, reset for 10 clocks then released.
  - First hsync falling edge 656*4+2 clocks after reset release.
  - Exactly 521 hsync pulses per vsync period.
  - hsync low for 384 clocks; vsync low during lines 490-491.
- Sprite fetch: pos (100,100), memory model returns addr[7:0] with RD_LAT=1.
  - Pixel (100,100) shows 0x00.
  - Pixel (105,102) shows mem_addr 517 and colour 0x05.
  - Pixel (99,100) shows BG_COLOR.
- Clipping: pos (500,400).
  - Pixel (639,479) reads addr 79*256+139.
  - Pixel (640,479) has de=0 and rgb=0, with no further mem_en on that line.
- Deferred update: pos_wr with (10,10) issued at line 200.
  - The rest of the frame still uses the old position.
  - The next frame has its sprite at (10,10).
  - pos_wr on the commit clock takes effect in the immediately following frame.
- Colour key: SPRITE_KEY_EN defined, mem_data 0xE3 inside the sprite.
  - Output is BG_COLOR.
  - Without the macro, output is 0xE3.
- Mid-frame reset and CLK_DIV=1 build:
  - Reset at line 300 restores the reset values, and timing restarts from (0,0).
  - With CLK_DIV=1, frame length is 416800 clocks.
